// File: rtl/mem_responder_if.sv
// Request/response bus between the multicycle controller and the unified memory.
interface mem_responder_if;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        mem_ready;
  logic        err;
  logic        busy;

  modport master (
    output MemRead,
    output MemWrite,
    output addr,
    output wdata,
    input  rdata,
    input  mem_ready,
    input  err,
    input  busy
  );

  modport slave (
    input  MemRead,
    input  MemWrite,
    input  addr,
    input  wdata,
    output rdata,
    output mem_ready,
    output err,
    output busy
  );
endinterface

// File: rtl/mem_responder.sv
// Unified instruction/data memory with a fixed, parameterised completion latency.
// One request is accepted at a time from IDLE; completion is a one-cycle mem_ready pulse,
// with err flagging misaligned, out-of-range or read+write requests.
module mem_responder #(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned LATENCY = 2
) (
  input logic            clk,
  input logic            reset,
  mem_responder_if.slave bus
);

  localparam int unsigned Depth   = 2 ** ADDR_W;
  localparam logic [3:0]  CntInit = 4'(LATENCY - 1);

  typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [31:0]       addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              rd_q, rd_d;
  logic              wr_q, wr_d;

  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              mem_ready_q, mem_ready_d;
  logic              err_q, err_d;
  logic              busy_q, busy_d;

  logic [DATA_W-1:0] mem [Depth];

  // Request currently being serviced: live inputs while accepting, latched copy afterwards.
  logic              cur_rd;
  logic              cur_wr;
  logic [31:0]       cur_addr;
  logic [DATA_W-1:0] cur_wdata;
  logic [ADDR_W-1:0] cur_idx;
  logic              cur_illegal;
  logic              done_entry;
  logic              mem_we;

  // Select the request view; with LATENCY==1 the accept edge is also the DONE entry edge.
  always_comb begin
    if (state_q == StIdle) begin
      cur_rd    = bus.MemRead;
      cur_wr    = bus.MemWrite;
      cur_addr  = bus.addr;
      cur_wdata = bus.wdata;
    end else begin
      cur_rd    = rd_q;
      cur_wr    = wr_q;
      cur_addr  = addr_q;
      cur_wdata = wdata_q;
    end
  end

  assign cur_idx     = cur_addr[ADDR_W+1:2];
  assign cur_illegal = (cur_rd & cur_wr) |
                       (cur_addr[1:0] != 2'b00) |
                       ((cur_addr >> (ADDR_W + 2)) != 32'd0);

  // The edge that moves the FSM into DONE performs the array access.
  assign done_entry = (state_d == StDone) && (state_q != StDone);
  // Reset at the commit edge discards the pending write.
  assign mem_we     = done_entry & reset & cur_wr & ~cur_illegal;

  // State and request registers, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      addr_q  <= 32'd0;
      wdata_q <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
    end
  end

  // Next-state logic: accept in IDLE, count down in WAIT, single cycle in DONE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    unique case (state_q)
      StIdle: begin
        if (bus.MemRead | bus.MemWrite) begin
          addr_d  = bus.addr;
          wdata_d = bus.wdata;
          rd_d    = bus.MemRead;
          wr_d    = bus.MemWrite;
          cnt_d   = CntInit;
          state_d = (LATENCY == 1) ? StDone : StWait;
        end
      end
      StWait: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Registered outputs: pulse and error on DONE entry, rdata only on read completion.
  always_comb begin
    mem_ready_d = done_entry;
    err_d       = done_entry & cur_illegal;
    busy_d      = (state_d != StIdle);
    rdata_d     = rdata_q;
    if (done_entry) begin
      if (cur_illegal) begin
        rdata_d = '0;
      end else if (cur_rd) begin
        rdata_d = mem[cur_idx];
      end
    end
  end

  // Output registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rdata_q     <= '0;
      mem_ready_q <= 1'b0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      rdata_q     <= rdata_d;
      mem_ready_q <= mem_ready_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
    end
  end

  // Storage array; contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[cur_idx] <= cur_wdata;
    end
  end

  assign bus.rdata     = rdata_q;
  assign bus.mem_ready = mem_ready_q;
  assign bus.err       = err_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;

  logic        clk   = 1'b0;
  logic        reset = 1'b0;
  logic        rd    = 1'b0;
  logic        wr    = 1'b0;
  logic [31:0] ad    = 32'd0;
  logic [31:0] wd    = 32'd0;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // Index 0: LATENCY=2 instance, index 1: LATENCY=1 instance; both see the same stimulus.
  mem_responder_if bus_l2 ();
  mem_responder_if bus_l1 ();

  assign bus_l2.MemRead  = rd;
  assign bus_l2.MemWrite = wr;
  assign bus_l2.addr     = ad;
  assign bus_l2.wdata    = wd;
  assign bus_l1.MemRead  = rd;
  assign bus_l1.MemWrite = wr;
  assign bus_l1.addr     = ad;
  assign bus_l1.wdata    = wd;

  mem_responder #(.ADDR_W(8), .DATA_W(32), .LATENCY(2)) u_dut_l2 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_l2)
  );

  mem_responder #(.ADDR_W(8), .DATA_W(32), .LATENCY(1)) u_dut_l1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_l1)
  );

  logic        a_ready [2];
  logic        a_err   [2];
  logic        a_busy  [2];
  logic [31:0] a_rdata [2];

  assign a_ready[0] = bus_l2.mem_ready;
  assign a_err[0]   = bus_l2.err;
  assign a_busy[0]  = bus_l2.busy;
  assign a_rdata[0] = bus_l2.rdata;
  assign a_ready[1] = bus_l1.mem_ready;
  assign a_err[1]   = bus_l1.err;
  assign a_busy[1]  = bus_l1.busy;
  assign a_rdata[1] = bus_l1.rdata;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Transaction-level model: an accepted request at edge a completes at edge a+LAT-1,
  // and the next request can be accepted from edge a+LAT+1 onwards.
  int unsigned lat [2] = '{2, 1};
  int unsigned edge_n = 0;
  bit          started = 0;
  bit          pend    [2];
  int unsigned acc_n   [2];
  int unsigned next_ok [2];
  bit          p_ill   [2];
  bit          p_rd    [2];
  logic [31:0] p_addr  [2];
  logic [31:0] p_wd    [2];
  logic [31:0] mm      [2][256];
  bit          mk      [2][256];
  bit          e_ready [2];
  bit          e_err   [2];
  bit          e_busy  [2];
  bit          e_known [2];
  logic [31:0] e_rdata [2];

  always @(posedge clk) begin
    edge_n++;
    if (!reset) started = 1;
    for (int i = 0; i < 2; i++) begin
      e_ready[i] = 0;
      e_err[i]   = 0;
      if (!reset) begin
        pend[i]    = 0;
        e_rdata[i] = 32'd0;
        e_known[i] = 1;
        e_busy[i]  = 0;
        next_ok[i] = edge_n + 1;
      end else begin
        if (!pend[i] && edge_n >= next_ok[i] && (rd || wr)) begin
          pend[i]   = 1;
          acc_n[i]  = edge_n;
          p_rd[i]   = rd;
          p_addr[i] = ad;
          p_wd[i]   = wd;
          p_ill[i]  = (rd && wr) || (ad % 4 != 0) || (ad >= 32'h400);
        end
        if (pend[i] && edge_n == acc_n[i] + lat[i] - 1) begin
          e_ready[i] = 1;
          e_err[i]   = p_ill[i];
          pend[i]    = 0;
          next_ok[i] = edge_n + 2;
          if (p_ill[i]) begin
            e_rdata[i] = 32'd0;
            e_known[i] = 1;
          end else if (p_rd[i]) begin
            e_known[i] = mk[i][int'(p_addr[i] >> 2)];
            e_rdata[i] = mm[i][int'(p_addr[i] >> 2)];
          end else begin
            mm[i][int'(p_addr[i] >> 2)] = p_wd[i];
            mk[i][int'(p_addr[i] >> 2)] = 1;
          end
        end
        e_busy[i] = pend[i] || e_ready[i];
      end
    end
  end

  // Cycle-by-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (started) begin
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("L%0d mem_ready @%0d", lat[i], edge_n), {31'd0, a_ready[i]}, {31'd0, e_ready[i]});
        chk($sformatf("L%0d err @%0d", lat[i], edge_n), {31'd0, a_err[i]}, {31'd0, e_err[i]});
        chk($sformatf("L%0d busy @%0d", lat[i], edge_n), {31'd0, a_busy[i]}, {31'd0, e_busy[i]});
        if (e_known[i]) chk($sformatf("L%0d rdata @%0d", lat[i], edge_n), a_rdata[i], e_rdata[i]);
      end
    end
  end

  task automatic drive(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
    rd = r;
    wr = w;
    ad = a;
    wd = d;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    rd = 1'b0;
    wr = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int cnt2;
    int cnt1;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset rdata", a_rdata[0], 32'd0);
    chk("reset busy", {31'd0, a_busy[0]}, 32'd0);
    reset = 1'b1;

    // Write then read back, both latencies.
    drive(1'b0, 1'b1, 32'h10, 32'hDEADBEEF);
    chk("t1 l2 busy after accept", {31'd0, a_busy[0]}, 32'd1);
    chk("t1 l2 no early ready", {31'd0, a_ready[0]}, 32'd0);
    chk("t1 l1 ready after accept", {31'd0, a_ready[1]}, 32'd1);
    idle(1);
    chk("t1 l2 ready", {31'd0, a_ready[0]}, 32'd1);
    chk("t1 l2 err", {31'd0, a_err[0]}, 32'd0);
    chk("t1 l1 ready cleared", {31'd0, a_ready[1]}, 32'd0);
    idle(1);
    chk("t1 l2 ready cleared", {31'd0, a_ready[0]}, 32'd0);
    chk("t1 l2 idle", {31'd0, a_busy[0]}, 32'd0);
    drive(1'b1, 1'b0, 32'h10, 32'd0);
    chk("t1 l1 rdata", a_rdata[1], 32'hDEADBEEF);
    idle(1);
    chk("t1 l2 read ready", {31'd0, a_ready[0]}, 32'd1);
    chk("t1 l2 rdata", a_rdata[0], 32'hDEADBEEF);
    idle(1);

    // Misaligned read and write.
    drive(1'b1, 1'b0, 32'h13, 32'd0);
    idle(1);
    chk("t2 misaligned read err", {31'd0, a_err[0]}, 32'd1);
    chk("t2 misaligned read ready", {31'd0, a_ready[0]}, 32'd1);
    chk("t2 misaligned read rdata", a_rdata[0], 32'd0);
    idle(1);
    drive(1'b0, 1'b1, 32'h12, 32'd0);
    idle(1);
    chk("t2 misaligned write err", {31'd0, a_err[0]}, 32'd1);
    chk("t2 misaligned write rdata", a_rdata[0], 32'd0);
    idle(1);
    drive(1'b1, 1'b0, 32'h10, 32'd0);
    idle(1);
    chk("t2 reread", a_rdata[0], 32'hDEADBEEF);
    idle(1);

    // Read and write together is illegal.
    drive(1'b1, 1'b1, 32'h10, 32'h1);
    idle(1);
    chk("t3 both strobes err", {31'd0, a_err[0]}, 32'd1);
    idle(1);
    drive(1'b1, 1'b0, 32'h10, 32'd0);
    idle(1);
    chk("t3 unchanged", a_rdata[0], 32'hDEADBEEF);
    chk("t3 reread err", {31'd0, a_err[0]}, 32'd0);
    idle(1);

    // Known contents at 0x20 for the reset-abort test.
    drive(1'b0, 1'b1, 32'h20, 32'hCAFE0020);
    idle(2);

    // Read held for three edges.
    cnt2 = 0;
    cnt1 = 0;
    rd = 1'b1;
    wr = 1'b0;
    ad = 32'h10;
    for (int k = 0; k < 6; k++) begin
      if (k == 3) rd = 1'b0;
      @(negedge clk);
      cnt2 += int'(a_ready[0]);
      cnt1 += int'(a_ready[1]);
      if (k < 3) chk($sformatf("t4 l2 busy k%0d", k), {31'd0, a_busy[0]}, (k < 2) ? 32'd1 : 32'd0);
    end
    chk("t4 l2 ready count", cnt2, 32'd1);
    chk("t4 l1 ready count", cnt1, 32'd2);

    // Read held long enough to start a second access at L2.
    rd = 1'b1;
    ad = 32'h10;
    repeat (5) @(negedge clk);
    idle(4);

    // Reset the edge after accepting a write.
    drive(1'b0, 1'b1, 32'h20, 32'h1234);
    rd = 1'b0;
    wr = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    chk("t5 no ready after abort", {31'd0, a_ready[0]}, 32'd0);
    chk("t5 idle after abort", {31'd0, a_busy[0]}, 32'd0);
    reset = 1'b1;
    idle(2);
    drive(1'b1, 1'b0, 32'h20, 32'd0);
    idle(1);
    chk("t5 read ready", {31'd0, a_ready[0]}, 32'd1);
    chk("t5 prior contents", a_rdata[0], 32'hCAFE0020);
    idle(1);

    // Out of range.
    drive(1'b1, 1'b0, 32'h400, 32'd0);
    idle(1);
    chk("t6 out of range err", {31'd0, a_err[0]}, 32'd1);
    chk("t6 out of range rdata", a_rdata[0], 32'd0);
    idle(1);
    drive(1'b0, 1'b1, 32'h8000_0000, 32'h55);
    idle(2);

    // A few more words, written then read back.
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, 1'b1, 32'h40 + 32'(4 * k), 32'h1000_0000 + 32'(k));
      idle(2);
    end
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 1'b0, 32'h40 + 32'(4 * k), 32'd0);
      idle(2);
    end
    chk("last word rdata", a_rdata[0], 32'h1000_0003);
    drive(1'b1, 1'b0, 32'h3FC, 32'd0);
    idle(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
